// File: rtl/filt_pass_sched.sv
// Filter pass scheduler for the ROM / RAM A / RAM B ping-pong image buffers.
// Owns the shared read port, routes filter writes, and tracks the displayed buffer.
module filt_pass_sched #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned PASS_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ALIGN_FRAME    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              kernel_i,
  input  logic              operator_i,
  input  logic              frame_start_i,
  input  logic              filt_done_i,
  input  logic              filt_wr_en_i,
  input  logic [ADDR_W-1:0] filt_rd_addr_i,
  input  logic [ADDR_W-1:0] vga_rd_addr_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_a_o,
  output logic              wr_en_b_o,
  output logic [1:0]        src_sel_o,
  output logic [1:0]        disp_sel_o,
  output logic              filt_start_o,
  output logic              filt_abort_o,
  output logic              kernel_o,
  output logic              operator_o,
  output logic              vga_blank_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [PASS_W-1:0] pass_count_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] SEL_ROM = 2'd0;
  localparam logic [1:0] SEL_A   = 2'd1;
  localparam logic [1:0] SEL_B   = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, LAUNCH, RUN} state_t;

  state_t            state_q, state_n;
  logic [1:0]        disp_q, disp_n;
  logic [1:0]        src_q, src_n;
  logic              dest_b_q, dest_b_n;   // 1: pass writes RAM B, 0: RAM A
  logic              kern_q, kern_n;
  logic              oper_q, oper_n;
  logic              tmo_q, tmo_n;
  logic              done_q, done_n;
  logic              fstart_q, fstart_n;
  logic              abort_q, abort_n;
  logic [PASS_W-1:0] pass_q, pass_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              filt_owns;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      disp_q   <= SEL_ROM;
      src_q    <= SEL_ROM;
      dest_b_q <= 1'b0;
      kern_q   <= 1'b0;
      oper_q   <= 1'b0;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
      fstart_q <= 1'b0;
      abort_q  <= 1'b0;
      pass_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      disp_q   <= disp_n;
      src_q    <= src_n;
      dest_b_q <= dest_b_n;
      kern_q   <= kern_n;
      oper_q   <= oper_n;
      tmo_q    <= tmo_n;
      done_q   <= done_n;
      fstart_q <= fstart_n;
      abort_q  <= abort_n;
      pass_q   <= pass_n;
      cnt_q    <= cnt_n;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state_q;
    disp_n   = disp_q;
    src_n    = src_q;
    dest_b_n = dest_b_q;
    kern_n   = kern_q;
    oper_n   = oper_q;
    tmo_n    = tmo_q;
    pass_n   = pass_q;
    cnt_n    = cnt_q;
    done_n   = 1'b0;
    fstart_n = 1'b0;
    abort_n  = 1'b0;

    if (state_q != IDLE && clear_i) begin
      // Clear overrides any pass activity, including a coincident done
      state_n = IDLE;
      abort_n = 1'b1;
      disp_n  = SEL_ROM;
      pass_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            disp_n = SEL_ROM;
            pass_n = '0;
            tmo_n  = 1'b0;
          end else if (start_i) begin
            kern_n   = kernel_i;
            oper_n   = operator_i;
            src_n    = disp_q;
            dest_b_n = (disp_q == SEL_A);
            tmo_n    = 1'b0;
            if (ALIGN_FRAME != 0) begin
              state_n = WAIT_FRAME;
            end else begin
              state_n  = LAUNCH;
              fstart_n = 1'b1;
            end
          end
        end
        WAIT_FRAME: begin
          if (frame_start_i) begin
            state_n  = LAUNCH;
            fstart_n = 1'b1;
          end
        end
        LAUNCH: begin
          state_n = RUN;
          cnt_n   = '0;
        end
        RUN: begin
          if (filt_done_i) begin
            state_n = IDLE;
            disp_n  = dest_b_q ? SEL_B : SEL_A;
            pass_n  = pass_q + PASS_W'(1);
            done_n  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_n = IDLE;
            abort_n = 1'b1;
            tmo_n   = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Read-port arbitration and write routing
  assign filt_owns   = (state_q == LAUNCH) || (state_q == RUN);
  assign rd_addr_o   = filt_owns ? filt_rd_addr_i : vga_rd_addr_i;
  assign vga_blank_o = filt_owns;
  assign wr_en_a_o   = filt_wr_en_i && (state_q == RUN) && !dest_b_q;
  assign wr_en_b_o   = filt_wr_en_i && (state_q == RUN) && dest_b_q;

  assign busy_o       = (state_q != IDLE);
  assign src_sel_o    = src_q;
  assign disp_sel_o   = disp_q;
  assign filt_start_o = fstart_q;
  assign filt_abort_o = abort_q;
  assign kernel_o     = kern_q;
  assign operator_o   = oper_q;
  assign done_o       = done_q;
  assign timeout_o    = tmo_q;
  assign pass_count_o = pass_q;

endmodule
